ram_scan_reader: RTL and testbench
==================================

// Module: ram_scan_reader
// PURPOSE
//   Read-side sequencer for the 16-entry x 2-bit block RAM. On start it walks
//   addresses 0..LAST_ADDR. It drives the RAM read port (r_en/r_addr), captures
//   r_data and holds each word on led_data for HOLD_CYCLES clocks, so stored
//   patterns are visible on the board LEDs. Sits directly downstream of the RAM.
// PARAMETERS
//   ADDR_W       4           RAM address width
//   DATA_W       2           RAM data width
//   LAST_ADDR    15          final address of a scan (<= 2**ADDR_W-1)
//   HOLD_CYCLES  12_000_000  display time per word in clk cycles (1 s @12MHz); >= 1
// PORTS
//   clk        in   1       12MHz system clock, single clock domain
//   rst_n      in   1       asynchronous active-low reset
//   start      in   1       level; sampled only in IDLE, begins a scan
//   loop       in   1       1 = wrap to address 0 after LAST_ADDR instead of stopping
//   r_en       out  1       RAM read enable, high exactly one cycle per word
//   r_addr     out  ADDR_W  RAM read address
//   r_data     in   DATA_W  RAM registered read data (valid 1 cycle after r_en)
//   led_data   out  DATA_W  captured word currently displayed
//   led_valid  out  1       led_data holds a word read during this or an earlier scan
//   busy       out  1       high in every state except IDLE
//   done       out  1       one-cycle pulse when a non-loop scan completes
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, addr=0, hold counter=0, led_data=0,
//     led_valid=0, done=0. r_en=0, busy=0 (decoded from state).
//   r_en  = (state==REQ); r_addr = addr register. busy = (state!=IDLE).
//   FSM IDLE -> REQ -> WAIT -> HOLD -> {REQ | DONE}; DONE -> IDLE:
//     IDLE: start=1 at edge -> REQ, addr=0, led_valid=0.
//     REQ : r_en=1 for 1 cycle; RAM latches mem[addr] at the closing edge -> WAIT.
//     WAIT: r_data valid; closing edge: led_data<=r_data, led_valid<=1,
//           counter<=HOLD_CYCLES-1 -> HOLD.
//     HOLD: counter decrements each cycle. At counter==0:
//           addr!=LAST_ADDR       -> addr+1, REQ
//           addr==LAST_ADDR, loop -> addr=0, REQ (loop sampled only here)
//           addr==LAST_ADDR, !loop -> DONE
//     DONE: done=1 for exactly one cycle -> IDLE.
//   Latency: start edge E0 -> r_en high in cycle after E0 -> led_data update at E0+2.
//   Word period = HOLD_CYCLES + 2 cycles. First r_en of the next word follows
//     HOLD_CYCLES cycles after the led_data update.
//   Boundaries:
//     - start held high: a new scan begins the cycle after DONE->IDLE.
//     - start while busy: ignored.
//     - loop dropped mid-scan: current pass completes to LAST_ADDR, then DONE.
//     - HOLD_CYCLES=1: HOLD lasts one cycle.
//     - addr never exceeds LAST_ADDR. No wrap is computed in ADDR_W arithmetic.
//     - r_data is ignored outside WAIT.
//     - led_data/led_valid persist after DONE until the next start or reset.
//     - rst_n low mid-scan: immediate return to reset values; no done pulse.
//   Counter width = max(1, $clog2(HOLD_CYCLES)).
// STRUCTURE
//   Shared header ram_defs.vh: ADDR_W/DATA_W defaults, FSM state localparams
//     (IDLE, REQ, WAIT, HOLD, DONE; 3-bit binary).
//   Sub-module hold_timer (load value, dec, zero flag) is natural; the rest is flat.
// TESTING  (bench: RAM instance with INIT_FILE mem[i]=i%4, HOLD_CYCLES=4, LAST_ADDR=15)
//   1 reset then start pulse, loop=0 -> led_data 0,1,2,3,0.. every 6 cycles; 16 r_en
//     pulses with addrs 0..15; done high 1 cycle, 96 cycles after start; busy low after.
//   2 start held high -> second scan's r_en(addr 0) one cycle after DONE->IDLE;
//     led_valid low for 2 cycles, then high.
//   3 loop=1 -> after addr 15, next r_en addr=0 with no done. Drop loop mid-pass
//     -> that pass ends at addr 15 with done.
//   4 start pulses during HOLD -> no change to addr sequence or timing.
//   5 rst_n low during HOLD at addr 7 -> all outputs at reset values same cycle;
//     no done; next start restarts at addr 0.
//   6 HOLD_CYCLES=1, LAST_ADDR=3 -> r_en every 3 cycles, addrs 0..3, done at cycle 12.

Source files
------------

// File: rtl/ram_scan_reader_pkg.sv
// Shared definitions for the RAM scan reader: FSM state encoding, default
// RAM geometry and the hold-counter width rule.
package ram_scan_reader_pkg;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_DATA_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Counter must hold HOLD_CYCLES-1; never narrower than one bit.
  function automatic int unsigned hold_cnt_width(input int unsigned hold_cycles);
    return (hold_cycles < 2) ? 1 : $clog2(hold_cycles);
  endfunction

endpackage

// File: rtl/ram_scan_reader_hold_timer.sv
// Down-counter that times how long each word stays on the LEDs.
// Loads a start value, decrements on request and flags when it reaches zero.
module ram_scan_reader_hold_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_q, count_d;

  // NOTE: count_d gets a default before any branch so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/ram_scan_reader.sv
// Read-side sequencer for the LED pattern RAM: walks addresses 0..LAST_ADDR,
// captures each registered read word and shows it on led_data for HOLD_CYCLES.
module ram_scan_reader
  import ram_scan_reader_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned LAST_ADDR   = 15,
  parameter int unsigned HOLD_CYCLES = 12_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              loop,
  output logic              r_en,
  output logic [ADDR_W-1:0] r_addr,
  input  logic [DATA_W-1:0] r_data,
  output logic [DATA_W-1:0] led_data,
  output logic              led_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned       CNT_W     = hold_cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(LAST_ADDR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] led_data_q, led_data_d;
  logic              led_valid_q, led_valid_d;
  logic              timer_load, timer_dec, timer_zero;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    led_data_d  = led_data_q;
    led_valid_d = led_valid_q;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_REQ;
          addr_d      = '0;
          led_valid_d = 1'b0;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // RAM output is valid only in this state; capture and start the hold.
        led_data_d  = r_data;
        led_valid_d = 1'b1;
        timer_load  = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (timer_zero) begin
          if (addr_q != LAST) begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_REQ;
          end else if (loop) begin
            addr_d  = '0;
            state_d = ST_REQ;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      led_data_q  <= '0;
      led_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      led_data_q  <= led_data_d;
      led_valid_q <= led_valid_d;
    end
  end

  ram_scan_reader_hold_timer #(
    .W (CNT_W)
  ) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (HOLD_LOAD),
    .dec      (timer_dec),
    .zero     (timer_zero)
  );

  assign r_en      = (state_q == ST_REQ);
  assign r_addr    = addr_q;
  assign led_data  = led_data_q;
  assign led_valid = led_valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_ram_scan_reader.sv
// Bench for ram_scan_reader: two instances (long and short scans) fed by a
// registered RAM model, checked every cycle against a per-word timing model.
module tb_ram_scan_reader;

  localparam int HOLD_A = 4;
  localparam int LAST_A = 15;
  localparam int HOLD_B = 1;
  localparam int LAST_B = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_a = 1'b0, loop_a = 1'b0, start_b = 1'b0, loop_b = 1'b0;
  logic       r_en_a, r_en_b;
  logic [3:0] r_addr_a, r_addr_b;
  logic [1:0] r_data_a = 2'd0, r_data_b = 2'd0;
  logic [1:0] led_a, led_b;
  logic       valid_a, valid_b, busy_a, busy_b, done_a, done_b;
  logic [1:0] mem [16];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  initial for (int i = 0; i < 16; i++) mem[i] = 2'(i % 4);

  // Registered-read RAM; outside the valid cycle the bus carries noise.
  always @(posedge clk) r_data_a <= r_en_a ? mem[r_addr_a] : 2'($urandom);
  always @(posedge clk) r_data_b <= r_en_b ? mem[r_addr_b] : 2'($urandom);

  ram_scan_reader #(.ADDR_W(4), .DATA_W(2), .LAST_ADDR(LAST_A), .HOLD_CYCLES(HOLD_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .loop(loop_a),
    .r_en(r_en_a), .r_addr(r_addr_a), .r_data(r_data_a),
    .led_data(led_a), .led_valid(valid_a), .busy(busy_a), .done(done_a)
  );

  ram_scan_reader #(.ADDR_W(4), .DATA_W(2), .LAST_ADDR(LAST_B), .HOLD_CYCLES(HOLD_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .loop(loop_b),
    .r_en(r_en_b), .r_addr(r_addr_b), .r_data(r_data_b),
    .led_data(led_b), .led_valid(valid_b), .busy(busy_b), .done(done_b)
  );

  // Reference: a scan is a sequence of words, each word lasting HOLD+2 cycles
  // (phase 0 = request, 1 = data returning, 2..HOLD+1 = display).
  typedef struct {
    bit active;
    bit done;
    int phase;
    int addr;
    int led;
    bit valid;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_idle();
    mdl_t m;
    m.active = 0; m.done = 0; m.phase = 0; m.addr = 0; m.led = 0; m.valid = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input bit go, input bit lp,
                                    input int hold, input int last);
    mdl_t n = m;
    if (m.done) begin
      n.done = 0;
    end else if (!m.active) begin
      if (go) begin
        n.active = 1; n.phase = 0; n.addr = 0; n.valid = 0;
      end
    end else begin
      if (m.phase == 1) begin
        n.led   = m.addr % 4;
        n.valid = 1;
      end
      if (m.phase < hold + 1) begin
        n.phase = m.phase + 1;
      end else if (m.addr < last) begin
        n.addr = m.addr + 1; n.phase = 0;
      end else if (lp) begin
        n.addr = 0; n.phase = 0;
      end else begin
        n.active = 0; n.done = 1;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic check_dut(input string who, input mdl_t m, input logic r_en,
                           input logic [3:0] r_addr, input logic [1:0] led,
                           input logic valid, input logic busy, input logic done);
    bit exp_ren = m.active && (m.phase == 0);
    check({who, ".r_en"},      int'(r_en),   int'(exp_ren));
    check({who, ".r_addr"},    int'(r_addr), m.addr);
    check({who, ".led_data"},  int'(led),    m.led);
    check({who, ".led_valid"}, int'(valid),  int'(m.valid));
    check({who, ".busy"},      int'(busy),   int'(m.active || m.done));
    check({who, ".done"},      int'(done),   int'(m.done));
  endtask

  task automatic check_all();
    check_dut("a", ma, r_en_a, r_addr_a, led_a, valid_a, busy_a, done_a);
    check_dut("b", mb, r_en_b, r_addr_b, led_b, valid_b, busy_b, done_b);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      ma = mdl_next(ma, start_a, loop_a, HOLD_A, LAST_A);
      mb = mdl_next(mb, start_b, loop_b, HOLD_B, LAST_B);
    end
    #1;
    check_all();
  endtask

  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    #1;
    ma = mdl_idle();
    mb = mdl_idle();
    check_all();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while ((busy_a || busy_b) && i < budget) begin
      step();
      i++;
    end
    check("idle_within_budget", int'(busy_a || busy_b), 0);
  endtask

  task automatic run_scan(input bit use_b, input bit noisy, input int exp_words,
                          input int exp_lat);
    int e0;
    int n_ren = 0;
    bit seen  = 0;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    step();
    e0 = cyc;
    start_a = 1'b0;
    start_b = 1'b0;
    if (use_b ? r_en_b : r_en_a) n_ren++;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (noisy) begin
        if (use_b) start_b = 1'($urandom % 2); else start_a = 1'($urandom % 2);
      end
      step();
      if (use_b ? r_en_b : r_en_a) n_ren++;
      if (use_b ? done_b : done_a) begin
        seen = 1;
        check("scan.done_latency", cyc - e0, exp_lat);
      end
    end
    start_a = 1'b0;
    start_b = 1'b0;
    check("scan.done_seen", int'(seen), 1);
    check("scan.r_en_count", n_ren, exp_words);
    repeat (2) step();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int d;
    bit got;
    int n_done;
    ma = mdl_idle();
    mb = mdl_idle();

    // Reset values, then a plain non-loop scan.
    pulse_reset();
    repeat (3) step();
    run_scan(1'b0, 1'b0, 16, 96);

    // Start held high: next scan begins right after DONE->IDLE.
    start_a = 1'b1;
    d   = -1;
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      step();
      if (done_a) d = cyc;
      else if (d >= 0 && r_en_a) begin
        check("held_start.restart_gap", cyc - d, 2);
        got = 1;
      end
    end
    check("held_start.restart_seen", int'(got), 1);
    start_a = 1'b0;
    wait_idle(300);

    // Looping scan never reports done; dropping loop ends the current pass.
    loop_a  = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    n_done  = 0;
    for (int i = 0; i < 130; i++) begin
      step();
      if (done_a) n_done++;
    end
    check("loop.no_done", n_done, 0);
    repeat ($urandom_range(0, 90)) step();
    loop_a = 1'b0;
    wait_idle(200);

    // Start noise while busy leaves timing untouched.
    run_scan(1'b0, 1'b1, 16, 96);

    // Reset while displaying address 7, then a clean restart.
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    for (int i = 0; i < 200 && !(ma.addr == 7 && ma.phase >= 2); i++) step();
    check("reset_mid.addr_before", int'(r_addr_a), 7);
    pulse_reset();
    repeat (2) step();
    run_scan(1'b0, 1'b0, 16, 96);

    // One-cycle hold, short scan.
    run_scan(1'b1, 1'b0, 4, 12);

    // Random soak on both instances.
    for (int i = 0; i < 1500; i++) begin
      start_a = 1'(($urandom % 8) == 0);
      start_b = 1'(($urandom % 8) == 0);
      if (($urandom % 16) == 0) loop_a = ~loop_a;
      if (($urandom % 16) == 0) loop_b = ~loop_b;
      if (($urandom % 400) == 0) pulse_reset();
      else step();
    end
    start_a = 1'b0;
    start_b = 1'b0;
    loop_a  = 1'b0;
    loop_b  = 1'b0;
    wait_idle(300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
